usb_in_ep_buf: RTL and testbench

USB_IN_EP_BUF -- requirements
Module: usb_in_ep_buf

---
 rtl/usb_ep_pkg.sv | 34 +++
 rtl/usb_ep_buf_ram.sv | 39 +++
 rtl/usb_in_ep_buf.sv | 206 ++++++++++++++++++++
 tb/tb_usb_in_ep_buf.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_ep_pkg
//  Description : Shared definitions for the USB endpoint packet buffers (IN and
//                OUT). Holds the endpoint FSM state encodings, the default
//                packet size and a pointer-width helper.
//  Contents    : DEF_MAX_PKT_SIZE   default buffer depth / max packet length
//                EP_STATE_W         width of the endpoint FSM state register
//                EP_ST_*            endpoint FSM state encodings
//                ep_ptr_w()         pointer width able to hold 0..depth
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_ep_pkg;

  // Default packet buffer depth in bytes; also the largest packet accepted.
  localparam int DEF_MAX_PKT_SIZE = 32;

  // Endpoint FSM state encodings. Kept as plain constants so that older
  // blocks comparing raw state codes keep working.
  localparam int          EP_STATE_W     = 3;
  localparam logic [2:0]  EP_ST_FILL     = 3'd0;  // producer filling buffer
  localparam logic [2:0]  EP_ST_READY    = 3'd1;  // packet closed, awaiting IN
  localparam logic [2:0]  EP_ST_SEND     = 3'd2;  // packet being transmitted
  localparam logic [2:0]  EP_ST_WAIT_ACK = 3'd3;  // sent, awaiting handshake
  localparam logic [2:0]  EP_ST_STALL    = 3'd4;  // endpoint halted

  // Pointer width that can represent every value 0..depth inclusive, so a
  // completely full buffer is distinguishable from an empty one.
  function automatic int ep_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : usb_ep_pkg
`default_nettype wire

// File: rtl/usb_ep_buf_ram.sv
`default_nettype none
// ============================================================================
//  Module      : usb_ep_buf_ram
//  Description : Byte-wide packet storage for a USB endpoint. One synchronous
//                write port and one asynchronous (combinational) read port.
//                Contents are not reset; the owning controller tracks which
//                locations hold valid data.
//  Ports       : clk        clock, write on rising edge
//                we_i       write enable
//                waddr_i    write address
//                wdata_i    write byte
//                raddr_i    read address
//                rdata_o    byte at raddr_i (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_ep_buf_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : usb_ep_buf_ram
`default_nettype wire

// File: rtl/usb_in_ep_buf.sv
`default_nettype none
// ============================================================================
//  Module      : usb_in_ep_buf
//  Description : Single-packet buffer for a USB IN endpoint. The endpoint side
//                fills the buffer and closes the packet; the protocol engine
//                transmits it on an IN token, replays it if the host retries
//                after a lost ACK, and frees it on ACK. Handles STALL,
//                SETUP-driven re-initialisation and DATA0/DATA1 toggling.
//  Ports       : clk, reset           clock / synchronous active-high reset
//                in_ep_req/_grant     endpoint access arbitration
//                in_ep_data_free/_put/_data   byte write interface
//                in_ep_data_done      close packet (no bytes = ZLP)
//                in_ep_stall          halt the endpoint
//                in_ep_acked          one-cycle pulse on host ACK
//                in_token/setup_token token arrival pulses
//                tx_data_avail/_get/tx_data   byte read interface to TX
//                tx_pkt_end, rx_ack   packet sent / handshake received
//                tx_nak, tx_stall     handshake to return to the host
//                tx_data_toggle       0 = DATA0, 1 = DATA1
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_in_ep_buf
  import usb_ep_pkg::*;
#(
  parameter int MAX_PKT_SIZE = DEF_MAX_PKT_SIZE
) (
  input  logic       clk,
  input  logic       reset,

  input  logic       in_ep_req,
  output logic       in_ep_grant,
  output logic       in_ep_data_free,
  input  logic       in_ep_data_put,
  input  logic [7:0] in_ep_data,
  input  logic       in_ep_data_done,
  input  logic       in_ep_stall,
  output logic       in_ep_acked,

  input  logic       in_token,
  input  logic       setup_token,

  output logic       tx_data_avail,
  input  logic       tx_data_get,
  output logic [7:0] tx_data,
  input  logic       tx_pkt_end,
  input  logic       rx_ack,

  output logic       tx_nak,
  output logic       tx_stall,
  output logic       tx_data_toggle
);

  localparam int AW    = $clog2(MAX_PKT_SIZE);
  localparam int PTR_W = ep_ptr_w(MAX_PKT_SIZE);

  localparam logic [PTR_W-1:0] PTR_ZERO = '0;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(MAX_PKT_SIZE);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [EP_STATE_W-1:0] state_q, state_d;
  logic [PTR_W-1:0]      wptr_q,  wptr_d;
  logic [PTR_W-1:0]      rptr_q,  rptr_d;
  logic                  toggle_q, toggle_d;
  logic                  acked_q,  acked_d;

  logic                  buf_we;
  logic                  wr_ok;
  logic [7:0]            buf_rdata;

  // --------------------------------------------------------------------------
  // Combinational outputs
  // --------------------------------------------------------------------------
  assign in_ep_grant     = in_ep_req && (state_q != EP_ST_STALL);
  assign in_ep_data_free = (state_q == EP_ST_FILL) && (wptr_q < PTR_MAX);
  assign tx_data_avail   = (state_q == EP_ST_SEND) && (rptr_q != wptr_q);
  assign tx_data         = buf_rdata;
  assign tx_nak          = (state_q == EP_ST_FILL);
  assign tx_stall        = (state_q == EP_ST_STALL);
  assign tx_data_toggle  = toggle_q;
  assign in_ep_acked     = acked_q;

  // A put only lands when the endpoint holds the grant and there is room.
  assign wr_ok = in_ep_data_put && in_ep_grant && in_ep_data_free;

  // --------------------------------------------------------------------------
  // Next-state logic. The FSM transition is computed first; STALL and SETUP
  // then override it, SETUP last so it wins over everything but reset.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    toggle_d = toggle_q;
    acked_d  = 1'b0;
    buf_we   = 1'b0;

    case (state_q)
      EP_ST_FILL: begin
        if (wr_ok) begin
          buf_we = 1'b1;
          wptr_d = wptr_q + PTR_ONE;
        end
        // Uses the post-write pointer so a put+done pair keeps its byte and
        // the packet closes as soon as the last slot is taken.
        if ((wptr_d == PTR_MAX) || in_ep_data_done) begin
          state_d = EP_ST_READY;
        end
      end

      EP_ST_READY: begin
        if (in_token) begin
          state_d = EP_ST_SEND;
          rptr_d  = PTR_ZERO;
        end
      end

      EP_ST_SEND: begin
        if (tx_data_get && tx_data_avail) begin
          rptr_d = rptr_q + PTR_ONE;
        end
        if (tx_pkt_end) begin
          state_d = EP_ST_WAIT_ACK;
        end
      end

      EP_ST_WAIT_ACK: begin
        if (rx_ack) begin
          acked_d  = 1'b1;
          toggle_d = ~toggle_q;
          wptr_d   = PTR_ZERO;
          rptr_d   = PTR_ZERO;
          state_d  = EP_ST_FILL;
        end else if (in_token) begin
          // Host retried: the ACK was lost, so resend the same data with the
          // same toggle. wptr is untouched, which preserves the packet.
          rptr_d  = PTR_ZERO;
          state_d = EP_ST_SEND;
        end
      end

      EP_ST_STALL: begin
        state_d = EP_ST_STALL;
      end

      default: begin
        state_d = EP_ST_FILL;
        wptr_d  = PTR_ZERO;
        rptr_d  = PTR_ZERO;
      end
    endcase

    if (setup_token) begin
      state_d  = EP_ST_FILL;
      wptr_d   = PTR_ZERO;
      rptr_d   = PTR_ZERO;
      toggle_d = 1'b1;      // data stage after SETUP always starts on DATA1
      acked_d  = 1'b0;
      buf_we   = 1'b0;
    end else if (in_ep_stall) begin
      state_d  = EP_ST_STALL;
      wptr_d   = PTR_ZERO;
      rptr_d   = PTR_ZERO;
      toggle_d = toggle_q;
      acked_d  = 1'b0;
      buf_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EP_ST_FILL;
      wptr_q   <= PTR_ZERO;
      rptr_q   <= PTR_ZERO;
      toggle_q <= 1'b0;
      acked_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      toggle_q <= toggle_d;
      acked_q  <= acked_d;
    end
  end

  // --------------------------------------------------------------------------
  // Byte storage. Pointers index with their low bits; a full write pointer is
  // never used to write because data_free is low at that point, and a read
  // at rptr == MAX_PKT_SIZE is never presented as valid.
  // --------------------------------------------------------------------------
  usb_ep_buf_ram #(
    .DEPTH (MAX_PKT_SIZE),
    .AW    (AW)
  ) u_buf_ram (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (in_ep_data),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

endmodule : usb_in_ep_buf
`default_nettype wire

// File: tb/tb_usb_in_ep_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_usb_in_ep_buf
//  Description : Self-checking bench for usb_in_ep_buf: directed scenarios
//                plus a randomized run compared against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_in_ep_buf;

  localparam int MAX = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_ep_req = 1'b0;
  logic       in_ep_grant;
  logic       in_ep_data_free;
  logic       in_ep_data_put = 1'b0;
  logic [7:0] in_ep_data = 8'h00;
  logic       in_ep_data_done = 1'b0;
  logic       in_ep_stall = 1'b0;
  logic       in_ep_acked;
  logic       in_token = 1'b0;
  logic       setup_token = 1'b0;
  logic       tx_data_avail;
  logic       tx_data_get = 1'b0;
  logic [7:0] tx_data;
  logic       tx_pkt_end = 1'b0;
  logic       rx_ack = 1'b0;
  logic       tx_nak;
  logic       tx_stall;
  logic       tx_data_toggle;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] pkt    [0:63];
  logic [7:0] rx_buf [0:127];
  logic       rx_tog [0:127];
  int         rx_n;

  // Reference model state (packet as a queue, phase as a plain integer)
  localparam int MS_FILL = 0, MS_READY = 1, MS_SEND = 2, MS_WAIT = 3, MS_STALL = 4;
  int         m_ph;
  logic [7:0] m_q [$];
  int         m_idx;
  logic       m_tog;
  logic       m_ack;

  usb_in_ep_buf #(.MAX_PKT_SIZE(MAX)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_ep_req       (in_ep_req),
    .in_ep_grant     (in_ep_grant),
    .in_ep_data_free (in_ep_data_free),
    .in_ep_data_put  (in_ep_data_put),
    .in_ep_data      (in_ep_data),
    .in_ep_data_done (in_ep_data_done),
    .in_ep_stall     (in_ep_stall),
    .in_ep_acked     (in_ep_acked),
    .in_token        (in_token),
    .setup_token     (setup_token),
    .tx_data_avail   (tx_data_avail),
    .tx_data_get     (tx_data_get),
    .tx_data         (tx_data),
    .tx_pkt_end      (tx_pkt_end),
    .rx_ack          (rx_ack),
    .tx_nak          (tx_nak),
    .tx_stall        (tx_stall),
    .tx_data_toggle  (tx_data_toggle)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    reset = 0; in_ep_req = 0; in_ep_data_put = 0; in_ep_data = 0;
    in_ep_data_done = 0; in_ep_stall = 0; in_token = 0; setup_token = 0;
    tx_data_get = 0; tx_pkt_end = 0; rx_ack = 0;
  endtask

  task automatic do_setup();
    setup_token = 1; cyc(); setup_token = 0;
  endtask

  task automatic do_pkt_end();
    tx_pkt_end = 1; cyc(); tx_pkt_end = 0;
  endtask

  task automatic put_bytes(input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      in_ep_req = 1; in_ep_data_put = 1; in_ep_data = pkt[i];
      in_ep_data_done = with_done && (i == n - 1);
      cyc();
    end
    in_ep_data_put = 0; in_ep_data_done = 0;
  endtask

  // Issue an IN token and drain the packet, bounded so a stuck avail ends.
  task automatic read_pkt();
    in_token = 1; cyc(); in_token = 0;
    rx_n = 0;
    while (tx_data_avail && rx_n < 100) begin
      rx_buf[rx_n] = tx_data;
      rx_tog[rx_n] = tx_data_toggle;
      rx_n++;
      tx_data_get = 1; cyc(); tx_data_get = 0;
    end
  endtask

  // Pulse rx_ack then count in_ep_acked highs over the following cycles.
  task automatic ack_and_count(output int cnt);
    rx_ack = 1; cyc(); rx_ack = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (in_ep_acked) cnt++;
      cyc();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clr();
    reset = 1; cyc(); cyc(); reset = 0;
    n_vec++; if (in_ep_grant !== 1'b0) begin n_err++; $display("FAIL reset_grant_noreq: got %b exp 0", in_ep_grant); end
    in_ep_req = 1; #1;
    n_vec++; if (in_ep_grant !== 1'b1) begin n_err++; $display("FAIL reset_grant_req: got %b exp 1", in_ep_grant); end
    n_vec++; if (in_ep_data_free !== 1'b1) begin n_err++; $display("FAIL reset_free: got %b exp 1", in_ep_data_free); end
    n_vec++; if (tx_data_avail !== 1'b0) begin n_err++; $display("FAIL reset_avail: got %b exp 0", tx_data_avail); end
    n_vec++; if (tx_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b exp 0", tx_stall); end
    n_vec++; if (tx_nak !== 1'b1) begin n_err++; $display("FAIL reset_nak: got %b exp 1", tx_nak); end
    n_vec++; if (tx_data_toggle !== 1'b0) begin n_err++; $display("FAIL reset_toggle: got %b exp 0", tx_data_toggle); end
    n_vec++; if (in_ep_acked !== 1'b0) begin n_err++; $display("FAIL reset_acked: got %b exp 0", in_ep_acked); end
    in_ep_req = 0;
  endtask

  task automatic test_basic();
    int cnt;
    clr();
    do_setup();
    n_vec++; if (tx_data_toggle !== 1'b1) begin n_err++; $display("FAIL basic_setup_toggle: got %b exp 1", tx_data_toggle); end
    pkt[0] = 8'h12; pkt[1] = 8'h01;
    for (int i = 2; i < 18; i++) pkt[i] = 8'($urandom);
    put_bytes(18, 1'b1);
    n_vec++; if (tx_nak !== 1'b0) begin n_err++; $display("FAIL basic_ready_nak: got %b exp 0", tx_nak); end
    n_vec++; if (in_ep_data_free !== 1'b0) begin n_err++; $display("FAIL basic_ready_free: got %b exp 0", in_ep_data_free); end
    read_pkt();
    n_vec++; if (rx_n !== 18) begin n_err++; $display("FAIL basic_len: got %0d exp 18", rx_n); end
    for (int i = 0; i < 18 && i < rx_n; i++) begin
      n_vec++; if (rx_buf[i] !== pkt[i]) begin n_err++; $display("FAIL basic_byte[%0d]: got %02h exp %02h", i, rx_buf[i], pkt[i]); end
      n_vec++; if (rx_tog[i] !== 1'b1) begin n_err++; $display("FAIL basic_send_toggle[%0d]: got %b exp 1", i, rx_tog[i]); end
    end
    do_pkt_end();
    ack_and_count(cnt);
    n_vec++; if (cnt !== 1) begin n_err++; $display("FAIL basic_acked_pulses: got %0d exp 1", cnt); end
    n_vec++; if (tx_data_toggle !== 1'b0) begin n_err++; $display("FAIL basic_toggle_after: got %b exp 0", tx_data_toggle); end
    n_vec++; if (tx_nak !== 1'b1) begin n_err++; $display("FAIL basic_fill_nak: got %b exp 1", tx_nak); end
    n_vec++; if (in_ep_data_free !== 1'b1) begin n_err++; $display("FAIL basic_fill_free: got %b exp 1", in_ep_data_free); end
  endtask

  task automatic test_overflow();
    int cnt;
    logic [7:0] all [0:39];
    clr();
    for (int i = 0; i < 40; i++) all[i] = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      in_ep_req = 1; in_ep_data_put = 1; in_ep_data = all[i];
      #1;
      n_vec++; if (in_ep_data_free !== (i < MAX)) begin n_err++; $display("FAIL ovf_free[%0d]: got %b exp %b", i, in_ep_data_free, (i < MAX)); end
      cyc();
    end
    in_ep_data_put = 0;
    read_pkt();
    n_vec++; if (rx_n !== MAX) begin n_err++; $display("FAIL ovf_len1: got %0d exp %0d", rx_n, MAX); end
    for (int i = 0; i < MAX && i < rx_n; i++) begin
      n_vec++; if (rx_buf[i] !== all[i]) begin n_err++; $display("FAIL ovf_byte1[%0d]: got %02h exp %02h", i, rx_buf[i], all[i]); end
    end
    do_pkt_end();
    ack_and_count(cnt);
    for (int i = 0; i < 8; i++) pkt[i] = all[32 + i];
    put_bytes(8, 1'b1);
    read_pkt();
    n_vec++; if (rx_n !== 8) begin n_err++; $display("FAIL ovf_len2: got %0d exp 8", rx_n); end
    for (int i = 0; i < 8 && i < rx_n; i++) begin
      n_vec++; if (rx_buf[i] !== all[32 + i]) begin n_err++; $display("FAIL ovf_byte2[%0d]: got %02h exp %02h", i, rx_buf[i], all[32 + i]); end
    end
    do_pkt_end();
    ack_and_count(cnt);
  endtask

  task automatic test_retry();
    int cnt;
    clr();
    do_setup();
    for (int i = 0; i < 18; i++) pkt[i] = 8'($urandom);
    put_bytes(18, 1'b1);
    read_pkt();
    do_pkt_end();
    n_vec++; if (in_ep_acked !== 1'b0) begin n_err++; $display("FAIL retry_no_ack: got %b exp 0", in_ep_acked); end
    read_pkt();
    n_vec++; if (rx_n !== 18) begin n_err++; $display("FAIL retry_len: got %0d exp 18", rx_n); end
    for (int i = 0; i < 18 && i < rx_n; i++) begin
      n_vec++; if (rx_buf[i] !== pkt[i]) begin n_err++; $display("FAIL retry_byte[%0d]: got %02h exp %02h", i, rx_buf[i], pkt[i]); end
      n_vec++; if (rx_tog[i] !== 1'b1) begin n_err++; $display("FAIL retry_toggle[%0d]: got %b exp 1", i, rx_tog[i]); end
    end
    do_pkt_end();
    ack_and_count(cnt);
    n_vec++; if (cnt !== 1) begin n_err++; $display("FAIL retry_acked_pulses: got %0d exp 1", cnt); end
    n_vec++; if (tx_data_toggle !== 1'b0) begin n_err++; $display("FAIL retry_toggle_after: got %b exp 0", tx_data_toggle); end
  endtask

  task automatic test_zlp();
    int cnt;
    clr();
    in_ep_req = 1; in_ep_data_done = 1; cyc(); in_ep_data_done = 0;
    n_vec++; if (tx_nak !== 1'b0) begin n_err++; $display("FAIL zlp_nak: got %b exp 0", tx_nak); end
    read_pkt();
    n_vec++; if (rx_n !== 0) begin n_err++; $display("FAIL zlp_len: got %0d exp 0", rx_n); end
    cyc();
    n_vec++; if (tx_data_avail !== 1'b0) begin n_err++; $display("FAIL zlp_avail: got %b exp 0", tx_data_avail); end
    do_pkt_end();
    ack_and_count(cnt);
    n_vec++; if (cnt !== 1) begin n_err++; $display("FAIL zlp_acked_pulses: got %0d exp 1", cnt); end
    n_vec++; if (tx_data_toggle !== 1'b1) begin n_err++; $display("FAIL zlp_toggle: got %b exp 1", tx_data_toggle); end
  endtask

  task automatic test_stall();
    int cnt;
    clr();
    do_setup();
    for (int i = 0; i < 5; i++) pkt[i] = 8'($urandom);
    put_bytes(5, 1'b0);
    in_ep_stall = 1; cyc(); in_ep_stall = 0;
    in_ep_req = 1; #1;
    n_vec++; if (tx_stall !== 1'b1) begin n_err++; $display("FAIL stall_tx_stall: got %b exp 1", tx_stall); end
    n_vec++; if (in_ep_grant !== 1'b0) begin n_err++; $display("FAIL stall_grant: got %b exp 0", in_ep_grant); end
    n_vec++; if (tx_nak !== 1'b0) begin n_err++; $display("FAIL stall_nak: got %b exp 0", tx_nak); end
    in_token = 1; cyc(); in_token = 0;
    n_vec++; if (tx_stall !== 1'b1) begin n_err++; $display("FAIL stall_token_ignored: got %b exp 1", tx_stall); end
    n_vec++; if (tx_data_avail !== 1'b0) begin n_err++; $display("FAIL stall_avail: got %b exp 0", tx_data_avail); end
    do_setup();
    n_vec++; if (tx_stall !== 1'b0) begin n_err++; $display("FAIL stall_clear: got %b exp 0", tx_stall); end
    n_vec++; if (tx_data_toggle !== 1'b1) begin n_err++; $display("FAIL stall_setup_toggle: got %b exp 1", tx_data_toggle); end
    n_vec++; if (tx_nak !== 1'b1) begin n_err++; $display("FAIL stall_setup_fill: got %b exp 1", tx_nak); end
    for (int i = 0; i < 3; i++) pkt[i] = 8'($urandom);
    put_bytes(3, 1'b1);
    read_pkt();
    n_vec++; if (rx_n !== 3) begin n_err++; $display("FAIL stall_pkt_len: got %0d exp 3", rx_n); end
    for (int i = 0; i < 3 && i < rx_n; i++) begin
      n_vec++; if (rx_buf[i] !== pkt[i]) begin n_err++; $display("FAIL stall_pkt_byte[%0d]: got %02h exp %02h", i, rx_buf[i], pkt[i]); end
    end
    do_pkt_end();
    ack_and_count(cnt);
  endtask

  task automatic test_reset_in_send();
    clr();
    do_setup();
    for (int i = 0; i < 10; i++) pkt[i] = 8'($urandom);
    put_bytes(10, 1'b1);
    in_token = 1; cyc(); in_token = 0;
    tx_data_get = 1; cyc(); cyc(); cyc();
    reset = 1; cyc(); reset = 0; tx_data_get = 0;
    n_vec++; if (tx_nak !== 1'b1) begin n_err++; $display("FAIL rst_send_fill: got %b exp 1", tx_nak); end
    n_vec++; if (tx_data_avail !== 1'b0) begin n_err++; $display("FAIL rst_send_avail: got %b exp 0", tx_data_avail); end
    n_vec++; if (tx_data_toggle !== 1'b0) begin n_err++; $display("FAIL rst_send_toggle: got %b exp 0", tx_data_toggle); end
    n_vec++; if (in_ep_data_free !== 1'b1) begin n_err++; $display("FAIL rst_send_free: got %b exp 1", in_ep_data_free); end
  endtask

  // Randomized run against a queue-based reference model.
  task automatic test_random();
    logic e_grant, e_free, e_avail;
    clr();
    reset = 1; cyc(); reset = 0;
    m_ph = MS_FILL; m_q.delete(); m_idx = 0; m_tog = 0; m_ack = 0;
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 499) == 0);
      setup_token     = ($urandom_range(0, 79) == 0);
      in_ep_stall     = ($urandom_range(0, 149) == 0);
      in_ep_req       = ($urandom_range(0, 9) != 0);
      in_ep_data_put  = ($urandom_range(0, 1) == 0);
      in_ep_data      = 8'($urandom);
      in_ep_data_done = ($urandom_range(0, 11) == 0);
      in_token        = ($urandom_range(0, 7) == 0);
      tx_data_get     = ($urandom_range(0, 9) < 6);
      tx_pkt_end      = ($urandom_range(0, 14) == 0);
      rx_ack          = ($urandom_range(0, 3) == 0);
      #1;
      e_grant = in_ep_req && (m_ph != MS_STALL);
      e_free  = (m_ph == MS_FILL) && (m_q.size() < MAX);
      e_avail = (m_ph == MS_SEND) && (m_idx < m_q.size());
      n_vec++; if (in_ep_grant !== e_grant) begin n_err++; $display("FAIL rnd_grant@%0d: got %b exp %b", c, in_ep_grant, e_grant); end
      n_vec++; if (in_ep_data_free !== e_free) begin n_err++; $display("FAIL rnd_free@%0d: got %b exp %b", c, in_ep_data_free, e_free); end
      n_vec++; if (tx_data_avail !== e_avail) begin n_err++; $display("FAIL rnd_avail@%0d: got %b exp %b", c, tx_data_avail, e_avail); end
      n_vec++; if (tx_nak !== (m_ph == MS_FILL)) begin n_err++; $display("FAIL rnd_nak@%0d: got %b exp %b", c, tx_nak, (m_ph == MS_FILL)); end
      n_vec++; if (tx_stall !== (m_ph == MS_STALL)) begin n_err++; $display("FAIL rnd_stall@%0d: got %b exp %b", c, tx_stall, (m_ph == MS_STALL)); end
      n_vec++; if (tx_data_toggle !== m_tog) begin n_err++; $display("FAIL rnd_toggle@%0d: got %b exp %b", c, tx_data_toggle, m_tog); end
      n_vec++; if (in_ep_acked !== m_ack) begin n_err++; $display("FAIL rnd_acked@%0d: got %b exp %b", c, in_ep_acked, m_ack); end
      if (e_avail) begin
        n_vec++; if (tx_data !== m_q[m_idx]) begin n_err++; $display("FAIL rnd_data@%0d: got %02h exp %02h", c, tx_data, m_q[m_idx]); end
      end
      // model update for this clock edge
      m_ack = 0;
      if (reset) begin
        m_ph = MS_FILL; m_q.delete(); m_idx = 0; m_tog = 0;
      end else if (setup_token) begin
        m_ph = MS_FILL; m_q.delete(); m_idx = 0; m_tog = 1;
      end else if (in_ep_stall) begin
        m_ph = MS_STALL; m_q.delete(); m_idx = 0;
      end else begin
        case (m_ph)
          MS_FILL: begin
            if (in_ep_data_put && e_grant && e_free) m_q.push_back(in_ep_data);
            if (m_q.size() == MAX || in_ep_data_done) m_ph = MS_READY;
          end
          MS_READY: if (in_token) begin m_ph = MS_SEND; m_idx = 0; end
          MS_SEND: begin
            if (tx_data_get && e_avail) m_idx++;
            if (tx_pkt_end) m_ph = MS_WAIT;
          end
          MS_WAIT: begin
            if (rx_ack) begin
              m_ack = 1; m_tog = ~m_tog; m_q.delete(); m_idx = 0; m_ph = MS_FILL;
            end else if (in_token) begin
              m_ph = MS_SEND; m_idx = 0;
            end
          end
          default: ;
        endcase
      end
      cyc();
    end
    clr();
  endtask

  initial begin
    clr();
    cyc();
    test_reset();
    test_basic();
    test_overflow();
    test_retry();
    test_zlp();
    test_stall();
    test_reset_in_send();
    test_random();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_usb_in_ep_buf
`default_nettype wire
